// File: rtl/kianv_mem_arbiter_pkg.sv
// Shared arbiter definitions: state encoding, default timeout read data
// and width helpers used by the arbiter and its picker.
package kianv_mem_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hffff_ffff;

  // Grant index width; a single master still gets a one-bit index.
  function automatic int arb_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timeout counter width, large enough to hold the limit itself.
  function automatic int arb_cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/kianv_arb_pick.sv
// Combinational grant picker: round-robin starting after the last grant,
// or fixed priority where the lowest requesting index wins.
module kianv_arb_pick
  import kianv_mem_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int GW          = arb_idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [GW-1:0]          i_last_grant,
  input  logic                   i_rr_mode,
  output logic [GW-1:0]          o_grant,
  output logic                   o_any_req
);

  int                     w_start;
  int                     w_cand;
  logic                   w_found;
  logic [NUM_MASTERS-1:0] w_mask;

  // Scan candidates in priority order and keep the first requester found.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_cand  = 0;
    w_mask  = '0;
    if (i_rr_mode) begin
      w_start = int'(i_last_grant) + 1;
    end else begin
      w_start = 0;
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_cand = (w_start + k) % NUM_MASTERS;
      w_mask = NUM_MASTERS'(1) << w_cand;
      if (!w_found && ((i_req & w_mask) != '0)) begin
        w_found = 1'b1;
        o_grant = GW'(w_cand);
      end else begin
        w_found = w_found;
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/kianv_mem_arbiter.sv
// N-master to 1-slave arbiter for the kianv mem_valid/mem_ready bus, with
// round-robin or fixed-priority grant and an optional per-transaction timeout.
module kianv_mem_arbiter
  import kianv_mem_arbiter_pkg::*;
#(
  parameter int                    NUM_MASTERS    = 2,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    RR_MODE        = 1,
  parameter int                    TIMEOUT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA  = DATA_WIDTH'(ARB_TIMEOUT_RDATA)
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [NUM_MASTERS-1:0]                m_valid,
  output logic [NUM_MASTERS-1:0]                m_ready,
  output logic [NUM_MASTERS-1:0]                m_err,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_wstrb,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH-1:0]                 m_rdata,
  output logic                                  mem_valid,
  input  logic                                  mem_ready,
  output logic [DATA_WIDTH/8-1:0]               mem_wstrb,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int GW = arb_idx_width(NUM_MASTERS);
  localparam int TW = arb_cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last_grant;
  logic [TW-1:0] r_tcnt;
  logic [GW-1:0] w_pick;
  logic          w_any_req;
  logic          w_timeout;
  logic          w_done;
  logic          w_sel;

  kianv_arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .GW          (GW)
  ) u_pick (
    .i_req        (m_valid),
    .i_last_grant (r_last_grant),
    .i_rr_mode    (RR_MODE != 0),
    .o_grant      (w_pick),
    .o_any_req    (w_any_req)
  );

  // A real mem_ready always beats a coincident timeout.
  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_state == ARB_BUSY) && !mem_ready
                     && (r_tcnt == TLAST);
  assign w_done    = (r_state == ARB_BUSY) && (mem_ready || w_timeout);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant, last-grant and timeout counter; last_grant resets so master 0 wins first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_MASTERS - 1);
      r_tcnt       <= '0;
    end else begin
      if ((r_state == ARB_IDLE) && w_any_req) begin
        r_grant <= w_pick;
        r_tcnt  <= '0;
      end else if ((r_state == ARB_BUSY) && !w_done) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      if (w_done) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_state_next = ARB_BUSY;
        end else begin
          w_state_next = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (w_done) begin
          w_state_next = ARB_IDLE;
        end else begin
          w_state_next = ARB_BUSY;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  // Output mux: granted master's slices drive the slave only while BUSY.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    m_ready   = '0;
    m_err     = '0;
    w_sel     = 1'b0;
    if (w_timeout) begin
      m_rdata = TIMEOUT_RDATA;
    end else begin
      m_rdata = mem_rdata;
    end
    if (r_state == ARB_BUSY) begin
      mem_valid = 1'b1;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        w_sel      = (r_grant == GW'(i));
        mem_addr  |= {ADDR_WIDTH{w_sel}} & m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata |= {DATA_WIDTH{w_sel}} & m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        mem_wstrb |= {SW{w_sel}} & m_wstrb[i*SW +: SW];
        m_ready[i] = w_done & w_sel;
        m_err[i]   = w_timeout & w_sel;
      end
    end else begin
      mem_valid = 1'b0;
    end
  end

endmodule

// File: doc/kianv_mem_arbiter.md
Name: kianv_mem_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the kianv mem_valid/mem_ready memory bus.
- Lets several kianv cores, or a core plus a DMA/video master, share one memory port.
- Round-robin or fixed-priority grant, with a per-transaction timeout and an error flag.
- Sits between the core top-levels and the SoC memory/IO decoder.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- TIMEOUT_CYCLES, 0, busy-cycle limit before forced completion; 0 disables.
- TIMEOUT_RDATA, 32'hffff_ffff, read data returned on timeout.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- m_valid  in  NUM_MASTERS  per-master request.
- m_ready  out  NUM_MASTERS  per-master completion pulse.
- m_err  out  NUM_MASTERS  per-master timeout flag, valid with m_ready.
- m_wstrb  in  NUM_MASTERS*DATA_WIDTH/8  packed strobes; master i occupies slice i.
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses.
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_rdata  out  DATA_WIDTH  read data, broadcast to all masters.
- mem_valid  out  1  slave request.
- mem_ready  in  1  slave completion.
- mem_wstrb  out  DATA_WIDTH/8  slave strobes; 0 = read.
- mem_addr  out  ADDR_WIDTH  slave address.
- mem_wdata  out  DATA_WIDTH  slave write data.
- mem_rdata  in  DATA_WIDTH  slave read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is resetn, asynchronous and active-low.
- Reset values: state IDLE; mem_valid, m_ready, m_err = 0; mem_addr, mem_wdata, mem_wstrb = 0. The round-robin pointer resets to NUM_MASTERS-1, so master 0 is favoured first.
- Reset asserted mid-transaction: outputs clear immediately and the transaction is abandoned without m_ready.
- Master protocol: a master holds m_valid and its addr/wdata/wstrb stable until it sees m_ready. It may reassert m_valid in the cycle after m_ready.
- IDLE state:
  - mem_valid = 0; mem_* outputs driven 0.
  - If any m_valid is high, the picker selects a grant index, it is registered, and the block enters BUSY. Request at cycle t gives mem_valid at t+1.
  - Round-robin: search starts at last_grant+1 and wraps modulo NUM_MASTERS.
  - Fixed priority: lowest index wins.
- BUSY state:
  - mem_valid = 1; mem_addr, mem_wdata and mem_wstrb are muxed combinationally from the granted master's slices.
  - The grant is held for the whole transaction; new requests do not pre-empt it.
- Completion:
  - On mem_ready=1 in BUSY, m_ready[grant] = 1 in the same cycle and m_rdata = mem_rdata.
  - last_grant is updated to grant and the block returns to IDLE. This gives one idle cycle between transactions.
- m_rdata outside a completion cycle follows mem_rdata and is don't-care to masters.
- Timeout (TIMEOUT_CYCLES > 0):
  - A counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When the counter equals TIMEOUT_CYCLES-1 and mem_ready=0, a forced completion occurs: m_ready[grant] = 1, m_err[grant] = 1, m_rdata = TIMEOUT_RDATA, and the block returns to IDLE.
  - If mem_ready and timeout coincide, mem_ready wins and m_err stays 0.
- Granted master drops m_valid in BUSY (protocol violation): the transaction still completes and m_ready still pulses.
- At most one bit of m_ready and of m_err is ever set.
- NUM_MASTERS = 1: the grant index is constant 0; behaviour is otherwise identical.
- The grant index is max(1, $clog2(NUM_MASTERS)) bits. The timeout counter is wide enough to hold TIMEOUT_CYCLES.

Decomposition:
- Shared defines header (alongside the existing riscv defines): arbiter state encoding (IDLE, BUSY) and default TIMEOUT_RDATA constant.
- One sub-module, kianv_arb_pick: combinational picker.
  - Inputs: request vector, last_grant, RR_MODE.
  - Outputs: grant index and any_req.
  - Parametrised by NUM_MASTERS.

Test Plan:
- Single read: m_valid[0]=1, addr 0x100. Expect mem_valid at t+1 with mem_addr=0x100 and mem_wstrb=0. Slave mem_ready with rdata 0xdeadbeef gives m_ready[0] pulse and m_rdata=0xdeadbeef.
- Round-robin fairness: NUM_MASTERS=3, all m_valid held high, slave ready after 1 cycle. Grant order is 0,1,2,0,1,2 with no master starved.
- Fixed priority: RR_MODE=0, masters 0 and 2 requesting continuously. Master 0 wins every arbitration; master 2 is granted only once master 0 drops m_valid.
- Write mux: master 1 writes addr 0x2000, wdata 0x12345678, wstrb 4'b0011 while master 0 is idle. The slave sees exactly these values throughout BUSY.
- Timeout: TIMEOUT_CYCLES=4, slave never ready. Expect m_ready[0]=1, m_err[0]=1 and m_rdata=0xffffffff on the 4th BUSY cycle; next cycle mem_valid=0. A coincident mem_ready on that cycle gives m_err=0.
- Reset mid-BUSY: deassert resetn during a transaction. mem_valid=0 asynchronously, no m_ready pulse, and after release master 0 is granted first.
